mux_n_pipe: RTL and testbench

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mux_n_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_mux_n_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way registered multiplexer with a valid/ready handshake on
// both sides and a saturating count of out-of-range selects.
//
// An accepted beat (i_valid && o_ready) captures channel i_select of i_data
// into the output register. If i_select names no existing channel, the beat
// carries all-zero data with o_sel_err=1, and o_err_cnt is incremented.
// Latency is one cycle. A stalled output (o_valid && !i_ready) holds.
//
// Build option: define MUX_N_PIPE_SKID_EN to add a one-entry skid register.
// With the skid, o_ready is a flop with no combinational path from i_ready.
// Without it, o_ready = !o_valid || i_ready.
//
// Parameters
//   WIDTH   data width of each channel and of o_data
//   NUM_IN  number of input channels (2..16)
//   SEL_W   select width, derived from NUM_IN; do not override
//
// Ports
//   i_clk      clock; all state changes on its rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    upstream beat valid
//   o_ready    block accepts a beat this cycle
//   i_select   channel index for the beat
//   i_data     flattened channels; channel k at [k*WIDTH +: WIDTH]
//   o_valid    output beat valid
//   i_ready    downstream accepts the output beat
//   o_data     selected data, registered
//   o_sel_err  current output beat came from an out-of-range select
//   o_err_cnt  saturating count of accepted out-of-range beats
module mux_n_pipe #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [SEL_W-1:0]        i_select,
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_sel_err,
  output logic [7:0]              o_err_cnt
);

  // ---------------------------------------------------------------------
  // Channel select. One-hot hit vector feeding an AND-OR mux, so an
  // out-of-range select naturally yields all-zero data and no hit.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]  chan [NUM_IN];
  logic [NUM_IN-1:0] hit;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_oob;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign chan[gi] = i_data[gi*WIDTH +: WIDTH];
      assign hit[gi]  = (i_select == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      sel_data = sel_data | (chan[k] & {WIDTH{hit[k]}});
    end
  end

  assign sel_oob = ~|hit;

  logic accept;
  assign accept = i_valid && o_ready;

  // ---------------------------------------------------------------------
  // Output register load control, produced by whichever build is selected.
  // ---------------------------------------------------------------------
  logic             out_load;
  logic [WIDTH-1:0] out_data_next;
  logic             out_err_next;

`ifdef MUX_N_PIPE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             ready_reg;
  logic             load_new;
  logic             load_skid;
  logic             skid_to_out;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_err_reg;

  // ready_reg tracks the state being entered, so o_ready is a pure flop
  // output. It stays 0 through reset and rises on the first edge after.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= EMPTY;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != SKID);
    end
  end

  always_comb begin
    state_next  = state_reg;
    load_new    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
          load_new   = 1'b1;
        end
      end
      FULL: begin
        if (accept && i_ready) begin
          load_new = 1'b1;              // pass-through, no bubble
        end else if (accept) begin
          state_next = SKID;            // output stalled: park new beat
          load_skid  = 1'b1;
        end else if (i_ready) begin
          state_next = EMPTY;
        end
      end
      SKID: begin
        // o_ready is 0 here, so no accept can coincide with the drain.
        if (i_ready) begin
          state_next  = FULL;
          skid_to_out = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_data_reg <= '0;
      skid_err_reg  <= 1'b0;
    end else if (load_skid) begin
      skid_data_reg <= sel_data;
      skid_err_reg  <= sel_oob;
    end
  end

  assign out_load      = load_new || skid_to_out;
  assign out_data_next = skid_to_out ? skid_data_reg : sel_data;
  assign out_err_next  = skid_to_out ? skid_err_reg  : sel_oob;
  assign o_valid       = (state_reg != EMPTY);
  assign o_ready       = ready_reg;

`else

  logic valid_reg;
  logic ready_en_reg;

  // ready_en_reg keeps o_ready low while reset is held and for the
  // remainder of the cycle in which it is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg    <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (accept) begin
        valid_reg <= 1'b1;
      end else if (i_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_load      = accept;
  assign out_data_next = sel_data;
  assign out_err_next  = sel_oob;
  assign o_valid       = valid_reg;
  assign o_ready       = ready_en_reg && (!valid_reg || i_ready);

`endif

  // ---------------------------------------------------------------------
  // Output register and error counter, common to both builds.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] data_reg;
  logic             err_reg;
  logic [7:0]       err_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg <= '0;
      err_reg  <= 1'b0;
    end else if (out_load) begin
      data_reg <= out_data_next;
      err_reg  <= out_err_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (accept && sel_oob && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign o_data    = data_reg;
  assign o_sel_err = err_reg;
  assign o_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Testbench for mux_n_pipe (WIDTH=64, NUM_IN=3, so select 3 is out of range).
// A queue of accepted beats is the reference: every cycle the output is
// compared with the queue head, o_ready with the expected capacity, and
// o_err_cnt with a saturating count. Works in both builds.
module tb_mux_n_pipe;

  localparam int WIDTH  = 64;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    valid;
  logic                    dut_ready;
  logic [SEL_W-1:0]        select;
  logic [NUM_IN*WIDTH-1:0] data;
  logic                    dut_valid;
  logic                    ready;
  logic [WIDTH-1:0]        out_data;
  logic                    sel_err;
  logic [7:0]              err_cnt;

  mux_n_pipe #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .o_ready   (dut_ready),
    .i_select  (select),
    .i_data    (data),
    .o_valid   (dut_valid),
    .i_ready   (ready),
    .o_data    (out_data),
    .o_sel_err (sel_err),
    .o_err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  beat_t q[$];
  int    cnt_model;
  bit    ready_en;
  int    passed;
  int    failed;
  int    total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_IN*WIDTH-1:0] rand_data();
    logic [NUM_IN*WIDTH-1:0] d;
    for (int i = 0; i < NUM_IN * 2; i++) begin
      d[i*32 +: 32] = $urandom;
    end
    return d;
  endfunction

  // Capacity of the block: one beat without the skid register, two with it.
  function automatic logic model_ready(input logic r);
`ifdef MUX_N_PIPE_SKID_EN
    return ready_en && (q.size() < 2);
`else
    return ready_en && ((q.size() == 0) || r);
`endif
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare just after,
  // then advance the model on the rising edge.
  task automatic cycle(input logic v, input logic r, input logic [SEL_W-1:0] s,
                       input logic [NUM_IN*WIDTH-1:0] d);
    logic  exp_ready;
    beat_t b;
    int    si;
    valid  = v;
    ready  = r;
    select = s;
    data   = d;
    #1;
    exp_ready = model_ready(r);
    check("o_ready", dut_ready, exp_ready);
    check("o_valid", dut_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("o_data", out_data, q[0].data);
      check("o_sel_err", sel_err, q[0].err);
    end
    check("o_err_cnt", err_cnt, cnt_model);
    @(posedge clk);
    if (rst_n) begin
      if ((q.size() > 0) && r) void'(q.pop_front());
      if (v && exp_ready) begin
        si = s;
        if (si < NUM_IN) begin
          b.data = d[si*WIDTH +: WIDTH];
          b.err  = 1'b0;
        end else begin
          b.data = '0;
          b.err  = 1'b1;
          if (cnt_model < 255) cnt_model++;
        end
        q.push_back(b);
      end
      ready_en = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [NUM_IN*WIDTH-1:0] d;
    passed    = 0;
    failed    = 0;
    total     = 0;
    cnt_model = 0;
    ready_en  = 1'b0;
    rst_n     = 1'b1;
    valid     = 1'b0;
    ready     = 1'b0;
    select    = '0;
    data      = '0;

    // Reset state, asserted between edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", dut_valid, 1'b0);
    check("rst_ready", dut_ready, 1'b0);
    check("rst_data", out_data, 64'h0);
    check("rst_sel_err", sel_err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back selects 0..3: A0, A1, A2, then an out-of-range zero beat
    d = {64'hA2, 64'hA1, 64'hA0};
    for (int s = 0; s < 4; s++) cycle(1'b1, 1'b1, SEL_W'(s), d);
    cycle(1'b0, 1'b1, 2'd0, d);
    check("err_cnt_one", err_cnt, 8'd1);

    // Stall after a DEAD beat on channel 2; inputs keep changing meanwhile
    d = rand_data();
    d[2*WIDTH +: WIDTH] = 64'hDEAD;
    cycle(1'b1, 1'b1, 2'd2, d);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, SEL_W'($urandom_range(0, 3)), rand_data());
    #1;
    check("stall_hold_data", out_data, 64'hDEAD);
    check("stall_hold_valid", dut_valid, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd0, rand_data());

    // 300 out-of-range beats: counter saturates at 255
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 2'd3, rand_data());
    cycle(1'b0, 1'b1, 2'd0, rand_data());
    check("err_cnt_sat", err_cnt, 8'd255);

    // 100 continuous beats with i_ready held high
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, SEL_W'($urandom_range(0, 2)), rand_data());

    // Reset pulled low mid-stall, between clock edges
    cycle(1'b1, 1'b0, 2'd1, rand_data());
    cycle(1'b1, 1'b0, 2'd0, rand_data());
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", dut_valid, 1'b0);
    check("midrst_err_cnt", err_cnt, 8'd0);
    check("midrst_data", out_data, 64'h0);
    check("midrst_ready", dut_ready, 1'b0);
    q.delete();
    cnt_model = 0;
    ready_en  = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b1, 2'd0, rand_data());
    cycle(1'b1, 1'b1, 2'd1, rand_data());
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 2'd0, rand_data());
    d = rand_data();
    cycle(1'b1, 1'b1, 2'd1, d);
    cycle(1'b0, 1'b1, 2'd0, rand_data());
    cycle(1'b0, 1'b1, 2'd0, rand_data());

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            SEL_W'($urandom_range(0, 3)), rand_data());
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd0, rand_data());
    check("drain_empty", dut_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
